// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: bus-side arbiter for a MESI snooping protocol.
// Grants one cache request at a time (round-robin), broadcasts it to every
// snooper, gathers snoop acks plus shared/flush responses, then returns one
// completion to the requester.
//
// Optional feature macro: SNOOP_UPGR_EN
//   defined   -> cmd 11 is broadcast as BusUpgr on bus_upgr
//   undefined -> cmd 11 is promoted to BusRdX and bus_upgr is tied to 0
//
// Handshake: req_valid[i] is held by cache i until req_ready[i] pulses. The
// one-hot req_ready pulse appears in the IDLE cycle where the grant is made,
// and the request is taken on that rising edge. cpl_valid is a one-cycle
// pulse with no back-pressure.
module snoop_bus_arbiter #(
    parameter int NUM_CACHES    = 4,
    parameter int ADDR_W        = 32,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic [NUM_CACHES-1:0]         req_valid,
    input  logic [2*NUM_CACHES-1:0]       req_cmd,
    input  logic [ADDR_W*NUM_CACHES-1:0]  req_addr,
    output logic [NUM_CACHES-1:0]         req_ready,
    output logic                          bus_valid,
    output logic [$clog2(NUM_CACHES)-1:0] bus_src,
    output logic                          bus_rd,
    output logic                          bus_rdx,
    output logic                          bus_upgr,
    output logic [ADDR_W-1:0]             bus_addr,
    input  logic [NUM_CACHES-1:0]         snp_ack,
    input  logic [NUM_CACHES-1:0]         snp_shared,
    input  logic [NUM_CACHES-1:0]         snp_flush,
    output logic                          cpl_valid,
    output logic [$clog2(NUM_CACHES)-1:0] cpl_dst,
    output logic                          cpl_shared,
    output logic                          cpl_flush,
    output logic                          cpl_timeout,
    output logic [1:0]                    dbgState
);

    localparam int SRC_W = $clog2(NUM_CACHES);
    localparam int TMR_W = $clog2(SNOOP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        RESP  = 2'd2
    } arbStateT;

    arbStateT state, stateNext;

    logic [SRC_W-1:0]      rrPtr;
    logic [SRC_W-1:0]      srcQ;
    logic [1:0]            cmdQ;
    logic [ADDR_W-1:0]     addrQ;
    logic [NUM_CACHES-1:0] ackMask;
    logic                  sharedAcc;
    logic                  flushAcc;
    logic                  timeoutQ;
    logic [TMR_W-1:0]      timer;

    logic [NUM_CACHES-1:0] eligible;
    logic                  grantFound;
    logic [SRC_W-1:0]      grantIdx;
    logic [SRC_W-1:0]      cand;
    logic [1:0]            grantCmd;

    logic [NUM_CACHES-1:0] nonSrc;
    logic [NUM_CACHES-1:0] ackNow;
    logic [NUM_CACHES-1:0] maskNext;
    logic                  allAcked;
    logic [TMR_W-1:0]      timerNext;
    logic                  timeoutHit;

    // A cache competes only with a real command; cmd 00 never wins a grant.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            eligible[i] = req_valid[i] && (req_cmd[2*i +: 2] != 2'b00);
        end
    end

    // Round-robin pick: first eligible index from rrPtr upward, wrapping.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            cand = SRC_W'((int'(rrPtr) + k) % NUM_CACHES);
            if (!grantFound && eligible[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    // Command actually broadcast; BusUpgr folds into BusRdX when disabled.
    always_comb begin
        grantCmd = req_cmd[2*grantIdx +: 2];
`ifndef SNOOP_UPGR_EN
        if (grantCmd == 2'b11) begin
            grantCmd = 2'b10;
        end
`endif
    end

    // Snoop bookkeeping for the current cycle; source-cache acks are masked.
    always_comb begin
        nonSrc          = '1;
        nonSrc[srcQ]    = 1'b0;
        ackNow          = snp_ack & nonSrc;
        maskNext        = ackMask | ackNow;
        allAcked        = ((maskNext & nonSrc) == nonSrc);
        timerNext       = timer + TMR_W'(1);
        timeoutHit      = (timerNext == TMR_W'(SNOOP_TIMEOUT));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: one grant per IDLE, leave BCAST on full ack or timeout.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grantFound) stateNext = BCAST;
            BCAST:   if (allAcked || timeoutHit) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Transaction datapath: latch at grant, accumulate during BCAST.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rrPtr     <= '0;
            srcQ      <= '0;
            cmdQ      <= 2'b00;
            addrQ     <= '0;
            ackMask   <= '0;
            sharedAcc <= 1'b0;
            flushAcc  <= 1'b0;
            timeoutQ  <= 1'b0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        srcQ      <= grantIdx;
                        cmdQ      <= grantCmd;
                        addrQ     <= req_addr[ADDR_W*grantIdx +: ADDR_W];
                        ackMask   <= '0;
                        sharedAcc <= 1'b0;
                        flushAcc  <= 1'b0;
                        timeoutQ  <= 1'b0;
                        timer     <= '0;
                        rrPtr     <= (grantIdx == SRC_W'(NUM_CACHES - 1)) ? '0
                                                                          : grantIdx + SRC_W'(1);
                    end
                end
                BCAST: begin
                    ackMask   <= maskNext;
                    sharedAcc <= sharedAcc | (|(snp_shared & ackNow));
                    flushAcc  <= flushAcc  | (|(snp_flush  & ackNow));
                    timer     <= timerNext;
                    // A full ack in the timeout cycle still counts as success.
                    timeoutQ  <= !allAcked;
                end
                default: ;
            endcase
        end
    end

    // Output decode; everything is quiet outside its owning state.
    always_comb begin
        req_ready   = '0;
        bus_valid   = 1'b0;
        bus_src     = '0;
        bus_rd      = 1'b0;
        bus_rdx     = 1'b0;
        bus_upgr    = 1'b0;
        bus_addr    = '0;
        cpl_valid   = 1'b0;
        cpl_dst     = '0;
        cpl_shared  = 1'b0;
        cpl_flush   = 1'b0;
        cpl_timeout = 1'b0;
        dbgState    = state;
        if (state == IDLE && grantFound && rst_b) begin
            req_ready[grantIdx] = 1'b1;
        end
        if (state == BCAST) begin
            bus_valid = 1'b1;
            bus_src   = srcQ;
            bus_addr  = addrQ;
            bus_rd    = (cmdQ == 2'b01);
            bus_rdx   = (cmdQ == 2'b10);
`ifdef SNOOP_UPGR_EN
            bus_upgr  = (cmdQ == 2'b11);
`endif
        end
        if (state == RESP) begin
            cpl_valid   = 1'b1;
            cpl_dst     = srcQ;
            cpl_shared  = sharedAcc;
            cpl_flush   = flushAcc;
            cpl_timeout = timeoutQ;
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed testbench for snoop_bus_arbiter (default NUM_CACHES=4,
// ADDR_W=32, SNOOP_TIMEOUT=15). Inputs change 1 time unit after the rising
// edge; outputs are checked there too, away from the active edge.
module tb_snoop_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int ST = 15;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_b;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_cmd;
    logic [AW*N-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic            bus_valid;
    logic [SW-1:0]   bus_src;
    logic            bus_rd;
    logic            bus_rdx;
    logic            bus_upgr;
    logic [AW-1:0]   bus_addr;
    logic [N-1:0]    snp_ack;
    logic [N-1:0]    snp_shared;
    logic [N-1:0]    snp_flush;
    logic            cpl_valid;
    logic [SW-1:0]   cpl_dst;
    logic            cpl_shared;
    logic            cpl_flush;
    logic            cpl_timeout;
    logic [1:0]      dbgState;

    int nChecks = 0;
    int nFails  = 0;
    logic [SW-1:0] expQ[$];

    logic [47:0] allOut;
    assign allOut = {req_ready, bus_valid, bus_src, bus_rd, bus_rdx, bus_upgr, bus_addr,
                     cpl_valid, cpl_dst, cpl_shared, cpl_flush, cpl_timeout};

    snoop_bus_arbiter dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .bus_valid   (bus_valid),
        .bus_src     (bus_src),
        .bus_rd      (bus_rd),
        .bus_rdx     (bus_rdx),
        .bus_upgr    (bus_upgr),
        .bus_addr    (bus_addr),
        .snp_ack     (snp_ack),
        .snp_shared  (snp_shared),
        .snp_flush   (snp_flush),
        .cpl_valid   (cpl_valid),
        .cpl_dst     (cpl_dst),
        .cpl_shared  (cpl_shared),
        .cpl_flush   (cpl_flush),
        .cpl_timeout (cpl_timeout),
        .dbgState    (dbgState)
    );

    // Clock and a global time limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int idx, input logic [1:0] cmd, input logic [AW-1:0] addr);
        req_valid[idx]          = 1'b1;
        req_cmd[2*idx +: 2]     = cmd;
        req_addr[AW*idx +: AW]  = addr;
    endtask

    task automatic clrReq(input int idx);
        req_valid[idx]         = 1'b0;
        req_cmd[2*idx +: 2]    = 2'b00;
        req_addr[AW*idx +: AW] = '0;
    endtask

    task automatic clrSnp();
        snp_ack    = '0;
        snp_shared = '0;
        snp_flush  = '0;
    endtask

    // Scoreboard: completion destination comes from the expected queue.
    task automatic checkCpl(input string tag, input logic sh, input logic fl, input logic to);
        logic [SW-1:0] e;
        chk({tag, "_cpl_valid"}, cpl_valid, 1'b1);
        chk({tag, "_bus_valid"}, bus_valid, 1'b0);
        if (expQ.size() == 0) begin
            chk({tag, "_expq_empty"}, 64'd0, 64'd1);
        end else begin
            e = expQ.pop_front();
            chk({tag, "_cpl_dst"}, cpl_dst, e);
        end
        chk({tag, "_cpl_shared"},  cpl_shared,  sh);
        chk({tag, "_cpl_flush"},   cpl_flush,   fl);
        chk({tag, "_cpl_timeout"}, cpl_timeout, to);
    endtask

    initial begin
        rst_b     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        req_addr  = '0;
        clrSnp();

        // Reset held 3 cycles, then idle with no requests.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", allOut, 48'd0);
        chk("reset_state", dbgState, 2'd0);
        rst_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("idle_outputs", allOut, 48'd0);
        end

        // Valid with cmd 00 is not eligible.
        setReq(1, 2'b00, 32'hdead_0000);
        #1;
        chk("cmd00_ready", req_ready, 4'b0000);
        tick();
        chk("cmd00_state", dbgState, 2'd0);
        clrReq(1);

        // BusRd from cache 2; caches 0,1,3 ack over three BCAST cycles.
        setReq(2, 2'b01, 32'h0000_1000);
        #1;
        chk("rd_ready", req_ready, 4'b0100);
        expQ.push_back(2'd2);
        tick();
        clrReq(2);
        chk("rd_bus_valid", bus_valid, 1'b1);
        chk("rd_bus_cmd", {bus_rd, bus_rdx, bus_upgr}, 3'b100);
        chk("rd_bus_src", bus_src, 2'd2);
        chk("rd_bus_addr", bus_addr, 32'h0000_1000);
        snp_ack = 4'b0001;
        tick();
        chk("rd_bcast2_rd", bus_rd, 1'b1);
        chk("rd_bcast2_src", bus_src, 2'd2);
        snp_ack    = 4'b0010;
        snp_shared = 4'b0010;
        tick();
        chk("rd_bcast3_valid", bus_valid, 1'b1);
        snp_ack    = 4'b1000;
        snp_shared = 4'b0000;
        tick();
        clrSnp();
        checkCpl("rd", 1'b1, 1'b0, 1'b0);
        tick();
        chk("rd_after_cpl", cpl_valid, 1'b0);
        chk("rd_after_state", dbgState, 2'd0);

        // Round robin from a fresh reset: caches 0 and 3 request continuously.
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        setReq(0, 2'b10, 32'h0000_a000);
        setReq(3, 2'b10, 32'h0000_a300);
        snp_ack = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            #1;
            if (r % 2 == 0) begin
                chk("rr_ready_0", req_ready, 4'b0001);
                expQ.push_back(2'd0);
            end else begin
                chk("rr_ready_3", req_ready, 4'b1000);
                expQ.push_back(2'd3);
            end
            tick();
            chk("rr_bus_src", bus_src, (r % 2 == 0) ? 2'd0 : 2'd3);
            chk("rr_bus_rdx", bus_rdx, 1'b1);
            tick();
            checkCpl("rr", 1'b0, 1'b0, 1'b0);
            tick();
        end
        clrReq(0);
        clrReq(3);
        clrSnp();
        #1;
        chk("rr_stop_ready", req_ready, 4'b0000);
        tick();
        chk("rr_stop_state", dbgState, 2'd0);

        // Timeout: cache 1 BusRdX, cache 3 never acks.
        setReq(1, 2'b10, 32'h0000_2040);
        #1;
        chk("to_ready", req_ready, 4'b0010);
        expQ.push_back(2'd1);
        tick();
        clrReq(1);
        snp_ack = 4'b0101;
        for (int c = 1; c <= ST; c++) begin
            chk("to_bcast_valid", bus_valid, 1'b1);
            tick();
            snp_ack = '0;
        end
        checkCpl("to", 1'b0, 1'b0, 1'b1);
        tick();

        // Final ack lands in the timeout cycle: full ack wins.
        setReq(1, 2'b10, 32'h0000_2080);
        #1;
        chk("to2_ready", req_ready, 4'b0010);
        expQ.push_back(2'd1);
        tick();
        clrReq(1);
        snp_ack = 4'b0101;
        for (int c = 1; c <= ST; c++) begin
            if (c == ST) snp_ack = 4'b1000;
            chk("to2_bcast_valid", bus_valid, 1'b1);
            tick();
            snp_ack = '0;
        end
        checkCpl("to2", 1'b0, 1'b0, 1'b0);
        tick();

        // Flush from cache 2 plus spurious ack/shared from the source cache 0.
        setReq(0, 2'b10, 32'h0000_3000);
        #1;
        chk("fl_ready", req_ready, 4'b0001);
        expQ.push_back(2'd0);
        tick();
        clrReq(0);
        snp_ack    = 4'b0101;
        snp_flush  = 4'b0100;
        snp_shared = 4'b0001;
        tick();
        chk("fl_still_bcast", bus_valid, 1'b1);
        snp_ack    = 4'b1010;
        snp_flush  = 4'b0000;
        snp_shared = 4'b0000;
        tick();
        clrSnp();
        checkCpl("fl", 1'b0, 1'b1, 1'b0);
        tick();

        // BusUpgr from cache 3, then reset in the middle of BCAST.
        setReq(3, 2'b11, 32'h0000_4000);
        #1;
        chk("up_ready", req_ready, 4'b1000);
        tick();
        clrReq(3);
        chk("up_bus_valid", bus_valid, 1'b1);
        chk("up_bus_src", bus_src, 2'd3);
`ifdef SNOOP_UPGR_EN
        chk("up_bus_cmd", {bus_rd, bus_rdx, bus_upgr}, 3'b001);
`else
        chk("up_bus_cmd", {bus_rd, bus_rdx, bus_upgr}, 3'b010);
`endif
        tick();
        chk("up_bcast2_valid", bus_valid, 1'b1);
        rst_b = 1'b0;
        #1;
        chk("up_reset_outputs", allOut, 48'd0);
        chk("up_reset_state", dbgState, 2'd0);
        tick();
        tick();
        rst_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("up_no_cpl", cpl_valid, 1'b0);
        end
        chk("expq_drained", expQ.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
